// File: rtl/pp_accumulator.sv
// Partial-product accumulator for the sequential 8x8 multiplier.
// Sums NUM_PP shifted partial products into a WIDTH-bit product, drives the
// index of the next expected partial product, pulses done for one cycle when
// the product is complete, and keeps a sticky carry-out flag per operation.
// Every output comes straight from a flop.
module pp_accumulator #(
    parameter int  WIDTH  = 16,
    parameter int  NUM_PP = 4,
    localparam int IDX_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             pp_valid,
    input  logic [WIDTH-1:0] pp_in,
    output logic [IDX_W-1:0] pp_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PP - 1);

    // Widened add: bit WIDTH of the result is the carry out of the accumulator.
    function automatic logic [WIDTH:0] add_carry(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        return {1'b0, a} + {1'b0, b};
    endfunction

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_s;
    logic [WIDTH:0]   sum_s;
    logic [IDX_W-1:0] pp_idx_s;
    logic             busy_s;
    logic             done_s;
    logic [WIDTH-1:0] product_s;
    logic             overflow_s;

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so they can be registered and still line up with the state they reflect.
    always_comb begin
        state_s    = state_r;
        acc_s      = acc_r;
        pp_idx_s   = pp_idx;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        product_s  = product;
        overflow_s = overflow;
        sum_s      = add_carry(acc_r, pp_in);

        case (state_r)
            ST_IDLE: begin
                // A beat arriving together with start is dropped on purpose.
                if (start) begin
                    state_s    = ST_ACCUM;
                    acc_s      = {WIDTH{1'b0}};
                    pp_idx_s   = {IDX_W{1'b0}};
                    overflow_s = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCUM: begin
                // start is ignored here: an operation always runs to completion.
                busy_s = 1'b1;
                if (pp_valid) begin
                    acc_s = sum_s[WIDTH-1:0];
                    if (sum_s[WIDTH]) begin
                        overflow_s = 1'b1;
                    end else begin
                        overflow_s = overflow;
                    end
                    if (pp_idx == LAST_IDX) begin
                        state_s   = ST_DONE;
                        product_s = sum_s[WIDTH-1:0];
                        pp_idx_s  = {IDX_W{1'b0}};
                        busy_s    = 1'b0;
                        done_s    = 1'b1;
                    end else begin
                        pp_idx_s = pp_idx + IDX_W'(1);
                    end
                end else begin
                    state_s = ST_ACCUM;
                end
            end

            ST_DONE: begin
                // start in the done cycle chains straight into the next operation;
                // product stays at the previous result until that one completes.
                if (start) begin
                    state_s    = ST_ACCUM;
                    acc_s      = {WIDTH{1'b0}};
                    pp_idx_s   = {IDX_W{1'b0}};
                    overflow_s = 1'b0;
                    busy_s     = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            default: begin
                state_s    = ST_IDLE;
                acc_s      = {WIDTH{1'b0}};
                pp_idx_s   = {IDX_W{1'b0}};
                product_s  = {WIDTH{1'b0}};
                overflow_s = 1'b0;
            end
        endcase
    end

    // State, accumulator and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            acc_r    <= {WIDTH{1'b0}};
            pp_idx   <= {IDX_W{1'b0}};
            busy     <= 1'b0;
            done     <= 1'b0;
            product  <= {WIDTH{1'b0}};
            overflow <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            pp_idx   <= pp_idx_s;
            busy     <= busy_s;
            done     <= done_s;
            product  <= product_s;
            overflow <= overflow_s;
        end
    end

endmodule
